// File: rtl/udp_audio_rx.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------------+
// | udp_audio_rx: UDP byte stream -> 16-bit PCM FIFO with prefill for the DAC   |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module udp_audio_rx #(
   parameter int FIFO_AW     = 10,
   parameter int PREFILL     = 256,
   parameter int UDP_HDR_LEN = 8,
   parameter int MAX_PAYLOAD = 1472
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               udp_rec_data_valid,
   input  logic [7:0]         udp_rec_rdata,
   input  logic [15:0]        udp_rec_data_length,
   input  logic               wav_rden,
   output logic [15:0]        wav_out_data,
   output logic [FIFO_AW:0]   fifo_level,
   output logic               playing,
   output logic [15:0]        underflow_cnt,
   output logic [15:0]        overflow_cnt
);

   localparam int              DEPTH     = 2 ** FIFO_AW;
   localparam logic [FIFO_AW:0] DEPTH_L  = DEPTH[FIFO_AW:0];
   localparam logic [FIFO_AW:0] PREFILL_L = PREFILL[FIFO_AW:0];
   localparam logic [15:0]     HDR_L     = UDP_HDR_LEN[15:0];
   localparam logic [15:0]     MAXP_L    = MAX_PAYLOAD[15:0];

   typedef enum logic [1:0] {IDLE, LO, HI, DROP} state_t;

   state_t               state;
   logic [15:0]          rem;
   logic [7:0]           low_byte;
   logic                 push_req;
   logic [15:0]          push_data;
   logic [15:0]          mem [0:DEPTH-1];
   logic [FIFO_AW-1:0]   wr_ptr;
   logic [FIFO_AW-1:0]   rd_ptr;

   logic [15:0] pay_len;
   logic        full, empty, pop, wr_en, ovf;

   always_comb begin
      pay_len = udp_rec_data_length - HDR_L;
      full    = (fifo_level == DEPTH_L);
      empty   = (fifo_level == '0);
      pop     = wav_rden & playing & ~empty;
      // a same-cycle pop frees the slot, so a push at full still lands
      wr_en   = push_req & (~full | pop);
      ovf     = push_req & full & ~pop;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         rem       <= '0;
         low_byte  <= '0;
         push_req  <= 1'b0;
         push_data <= '0;
      end else begin
         push_req <= 1'b0;
         case (state)
            IDLE: if (udp_rec_data_valid) begin
               if (udp_rec_data_length < HDR_L || pay_len == 16'd0 || pay_len > MAXP_L) begin
                  state <= DROP;
               end else begin
                  low_byte <= udp_rec_rdata;
                  rem      <= pay_len - 16'd1;
                  state    <= HI;
               end
            end
            LO: begin
               if (rem == 16'd0)               state <= udp_rec_data_valid ? DROP : IDLE;
               else if (!udp_rec_data_valid)   state <= IDLE;
               else begin
                  low_byte <= udp_rec_rdata;
                  rem      <= rem - 16'd1;
                  state    <= HI;
               end
            end
            HI: begin
               // ending here leaves a lone low byte, which is simply dropped
               if (rem == 16'd0)               state <= udp_rec_data_valid ? DROP : IDLE;
               else if (!udp_rec_data_valid)   state <= IDLE;
               else begin
                  push_req  <= 1'b1;
                  push_data <= {udp_rec_rdata, low_byte};
                  rem       <= rem - 16'd1;
                  state     <= LO;
               end
            end
            DROP: if (!udp_rec_data_valid) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         fifo_level    <= '0;
         playing       <= 1'b0;
         wav_out_data  <= '0;
         underflow_cnt <= '0;
         overflow_cnt  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (pop)   rd_ptr <= rd_ptr + 1'b1;

         case ({wr_en, pop})
            2'b10:   fifo_level <= fifo_level + 1'b1;
            2'b01:   fifo_level <= fifo_level - 1'b1;
            default: fifo_level <= fifo_level;
         endcase

         if (ovf && overflow_cnt != 16'hFFFF) overflow_cnt <= overflow_cnt + 16'd1;

         if (wav_rden) begin
            if (pop) begin
               wav_out_data <= mem[rd_ptr];
            end else begin
               wav_out_data <= '0;
               if (playing) begin
                  playing <= 1'b0;
                  if (underflow_cnt != 16'hFFFF) underflow_cnt <= underflow_cnt + 16'd1;
               end
            end
         end

         if (!playing && fifo_level >= PREFILL_L) playing <= 1'b1;
      end
   end

endmodule
`default_nettype wire
